muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit of the EX stage, directly downstream of instruction decode. It consumes the decoded register operands (Rdata1 = rs, Rdata2 = rt) for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It owns the architectural HI/LO registers and computes one radix-2 step per cycle. It reports Busy/Done so the pipeline controller can stall MFHI/MFLO and further mul/div issue.

## Interface
- No parameters. Width is fixed at 32 bits.
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- Start  in  1  issue request, sampled only in IDLE.
- Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
- Rdata1  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data).
- Rdata2  in  32  rt operand (multiplier / divisor).
- Busy  out  1  high while an operation is in progress.
- Done  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

## Operation
- Three states:
  - IDLE: waiting for an issue.
  - CALC: 32 iterations, driven by a 5-bit counter.
  - FIX: sign correction and HI/LO write.
- **Issue (IDLE, Start=1, Op=MULT/MULTU/DIV/DIVU):**
  - Latch the operands.
  - For signed ops, latch the magnitudes and the operand signs.
  - Clear the counter and go to CALC.
- **MTHI/MTLO (IDLE, Start=1):** HI (resp. LO) ← Rdata1 at that edge. No Busy, no Done, stay in IDLE.
- **Reserved Op, or Start outside IDLE:** ignored. No state change.
- **Multiply:** shift-add over a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- **Divide:** restoring divide, one quotient bit per cycle, MSB first. 64-bit remainder/quotient shift register.
- **FIX state:**
  - Signed MULT: negate the 64-bit product if the operand signs differ.
  - Signed DIV: quotient sign = sign(rs) XOR sign(rt); remainder takes the sign of rs.
  - Write {HI, LO} = product, or HI = remainder and LO = quotient. Return to IDLE.
- **Divide by zero (rt = 0), signed or unsigned:** HI = Rdata1 unmodified, LO = 32'hFFFF_FFFF. No sign fix. Latency is normal.
- **DIV 0x8000_0000 / 0xFFFF_FFFF:** LO = 0x8000_0000, HI = 0. This is the natural wrap; no exception.
- HI/LO change only at the FIX edge or on MTHI/MTLO. During CALC they hold their previous values.

## Timing
- Reset values: state IDLE, counter 0, Busy 0, Done 0, HI 0, LO 0.
- RST has priority over everything, including mid-CALC and FIX. An in-flight operation is discarded.
- Cycle sequence, with E0 the issue edge:
  - E0: issue.
  - E1..E32: CALC iterations.
  - E33: FIX writes HI/LO.
- Busy is high from after E0 through before E33, i.e. 33 cycles. Done is high for exactly the one cycle after E33. Busy = 0 in the Done cycle.
- Result is visible on HI/LO in the Done cycle, 33 cycles after issue.
- Start in the Done cycle is accepted, giving back-to-back operations with no bubble.
- MTHI/MTLO: the value is visible the cycle after E0.
- Busy and Done are registered. There is no combinational path from Start to outputs.

## Structure
- Op encodings and the state encodings (IDLE, CALC, FIX) go in the shared common_param.vh, next to the existing format constants.
- Single module, no sub-module. Multiply and divide share the 64-bit shift register, the 33-bit adder/subtractor and the counter.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI = 0xFFFF_FFFE, LO = 0x0000_0001. Done pulses exactly 33 cycles after issue; Busy high for 33 cycles.
- MULT −3 × 7 → HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB. MULT 0 × 0x8000_0000 → HI = LO = 0.
- DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIVU 7 / 0 → HI = 7, LO = 0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF → LO = 0x8000_0000, HI = 0. Issue DIVU 100/7 in the Done cycle → LO = 14, HI = 2, 33 cycles later.
- Start with a new Op during CALC → ignored, original result unchanged. RST asserted at iteration 10 → Busy/Done/HI/LO = 0 next cycle; a subsequent MULTU 5×6 → LO = 30.
- MTHI 0x1234_5678 in IDLE → HI = 0x1234_5678 next cycle, Busy stays 0, Done stays 0. MTLO during Busy → ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op and state encodings shared by the multiply/divide unit
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative radix-2 multiply/divide unit owning HI/LO
// Multiply and divide share one 64-bit shift register, one adder and the step counter.
module muldiv
  import muldiv_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  state_e      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] b;
  logic [31:0] a_raw;
  logic        is_div;
  logic        is_signed;
  logic        sign_a;
  logic        sign_b;
  logic        div_zero;

  logic [31:0] mag1, mag2;
  logic [33:0] x_op, y_op, sum;
  logic [63:0] step;
  logic [63:0] prod_fix;
  logic [31:0] q_fix, r_fix;

  always_comb begin
    mag1 = Op[0] ? Rdata1 : abs32(Rdata1);
    mag2 = Op[0] ? Rdata2 : abs32(Rdata2);

    // Divide subtracts the divisor from the shifted partial remainder; sum[33] is the borrow.
    x_op = is_div ? {1'b0, acc[63:31]} : {2'b00, acc[63:32]};
    y_op = is_div ? ~{2'b00, b} : {2'b00, b};
    sum  = x_op + y_op + {33'd0, is_div};

    if (is_div)
      step = sum[33] ? {acc[62:0], 1'b0} : {sum[31:0], acc[30:0], 1'b1};
    else
      step = acc[0] ? {sum[32:0], acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};

    prod_fix = (is_signed && (sign_a ^ sign_b)) ? (~acc + 64'd1) : acc;
    q_fix    = (is_signed && (sign_a ^ sign_b)) ? (~acc[31:0] + 32'd1) : acc[31:0];
    r_fix    = (is_signed && sign_a) ? (~acc[63:32] + 32'd1) : acc[63:32];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      acc       <= 64'd0;
      b         <= 32'd0;
      a_raw     <= 32'd0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (op_e'(Op))
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                is_div    <= Op[1];
                is_signed <= ~Op[0];
                sign_a    <= ~Op[0] & Rdata1[31];
                sign_b    <= ~Op[0] & Rdata2[31];
                b         <= Op[1] ? mag2 : mag1;
                acc       <= {32'd0, Op[1] ? mag1 : mag2};
                a_raw     <= Rdata1;
                div_zero  <= Op[1] && (Rdata2 == 32'd0);
                cnt       <= 5'd0;
                Busy      <= 1'b1;
                state     <= S_CALC;
              end
              OP_MTHI: HI <= Rdata1;
              OP_MTLO: LO <= Rdata1;
              default: ;
            endcase
          end
        end
        S_CALC: begin
          acc <= step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= S_FIX;
        end
        S_FIX: begin
          if (div_zero) begin
            HI <= a_raw;
            LO <= 32'hFFFF_FFFF;
          end else if (is_div) begin
            HI <= r_fix;
            LO <= q_fix;
          end else begin
            HI <= prod_fix[63:32];
            LO <= prod_fix[31:0];
          end
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - scoreboard bench for muldiv with directed vectors
module tb_muldiv;

  logic        CLK = 1'b0;
  logic        RST;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] Rdata1, Rdata2;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  always #5 CLK = ~CLK;

  muldiv dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_n;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Done=1 expected no pending op");
      end else begin
        e = sb.pop_front();
        check32({e.name, "_hi"}, HI, e.hi);
        check32({e.name, "_lo"}, LO, e.lo);
        checkint({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  // Caller is at a negedge; drives one Start cycle across the next posedge.
  task automatic pulse(input logic [2:0] op, input logic [31:0] a, input logic [31:0] bb);
    Start = 1'b1; Op = op; Rdata1 = a; Rdata2 = bb;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] bb,
                       input string name, input logic [31:0] ehi, input logic [31:0] elo);
    pulse(op, a, bb);
    sb.push_back('{ehi, elo, cyc + 33, name});
  endtask

  task automatic wait_done(input string name, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      if (Done === 1'b1) seen = 1'b1;
      else if (Busy === 1'b1) n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no Done expected Done within 100 cycles", name);
    end
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; Op = 3'b000; Rdata1 = 32'd0; Rdata2 = 32'd0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check32("reset_busy", {31'd0, Busy}, 32'd0);
    check32("reset_done", {31'd0, Done}, 32'd0);
    check32("reset_hi", HI, 32'd0);
    check32("reset_lo", LO, 32'd0);

    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu_max", busy_n);
    checkint("multu_busy_cycles", busy_n, 33);
    check32("busy_in_done_cycle", {31'd0, Busy}, 32'd0);

    issue(3'b000, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done("mult_neg3x7", busy_n);
    issue(3'b000, 32'd0, 32'h8000_0000, "mult_zero", 32'd0, 32'd0);
    wait_done("mult_zero", busy_n);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_neg7_2", busy_n);
    issue(3'b011, 32'd7, 32'd0, "divu_by0", 32'd7, 32'hFFFF_FFFF);
    wait_done("divu_by0", busy_n);
    issue(3'b010, 32'hFFFF_FFFB, 32'd0, "div_by0", 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    wait_done("div_by0", busy_n);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_wrap", 32'd0, 32'h8000_0000);
    wait_done("div_wrap", busy_n);
    issue(3'b011, 32'd100, 32'd7, "divu_b2b", 32'd2, 32'd14);
    wait_done("divu_b2b", busy_n);

    // Start and MTLO during CALC must be ignored.
    @(negedge CLK);
    issue(3'b001, 32'd3, 32'd4, "multu_ignored_start", 32'd0, 32'd12);
    repeat (5) @(negedge CLK);
    pulse(3'b011, 32'd50, 32'd5);
    @(negedge CLK);
    pulse(3'b101, 32'hDEAD_BEEF, 32'd0);
    @(negedge CLK);
    check32("mtlo_busy_lo", LO, 32'd14);
    check32("calc_hold_hi", HI, 32'd2);
    wait_done("multu_ignored_start", busy_n);

    // Reserved op in IDLE does nothing.
    @(negedge CLK);
    pulse(3'b110, 32'h1111_1111, 32'h2222_2222);
    @(negedge CLK);
    check32("reserved_busy", {31'd0, Busy}, 32'd0);
    check32("reserved_lo", LO, 32'd12);

    // Reset mid-CALC discards the operation.
    pulse(3'b001, 32'd9, 32'd9);
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check32("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check32("rst_mid_done", {31'd0, Done}, 32'd0);
    check32("rst_mid_hi", HI, 32'd0);
    check32("rst_mid_lo", LO, 32'd0);
    issue(3'b001, 32'd5, 32'd6, "multu_after_rst", 32'd0, 32'd30);
    wait_done("multu_after_rst", busy_n);

    @(negedge CLK);
    pulse(3'b100, 32'h1234_5678, 32'd0);
    @(negedge CLK);
    check32("mthi_hi", HI, 32'h1234_5678);
    check32("mthi_busy", {31'd0, Busy}, 32'd0);
    check32("mthi_done", {31'd0, Done}, 32'd0);
    check32("mthi_lo", LO, 32'd30);

    repeat (5) @(negedge CLK);
    checkint("pending_ops", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
